// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : PLL areset pulse, lock wait with timeout/retries, lock stability
//            qualification, downstream reset release and lock-loss monitoring.
//            Optional lock-loss counter built when PLL_SEQ_LOSS_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int ARESET_CYCLES = 8,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             restart,
    output logic             pll_areset,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int c_tmax_ls = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int c_tmax    = (c_tmax_ls > ARESET_CYCLES) ? c_tmax_ls : ARESET_CYCLES;
    localparam int TIMER_W   = (c_tmax > 2) ? $clog2(c_tmax) : 1;
    localparam int RETRY_W   = (MAX_RETRIES > 2) ? $clog2(MAX_RETRIES) : 1;

    localparam logic [TIMER_W-1:0] c_areset_last = TIMER_W'(ARESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_lock_last   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] c_stable_last = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] c_retry_last  = RETRY_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [1:0]           sync_q, sync_d;
    logic                 pll_areset_q, pll_areset_d;
    logic                 sys_rst_q, sys_rst_d;
    logic                 fault_q, fault_d;
    logic                 w_fail;
    logic                 w_locked_s;

    assign w_locked_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], pll_locked};
        state_d = state_q;
        timer_d = timer_q + TIMER_W'(1);
        retry_d = retry_q;
        w_fail  = 1'b0;

        case (state_q)
            RESET_PLL: begin
                if (timer_q == c_areset_last) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock takes precedence over a coincident timeout.
                if (w_locked_s) begin
                    state_d = STABLE;
                    timer_d = '0;
                end else if (timer_q == c_lock_last) begin
                    w_fail = 1'b1;
                end
            end
            STABLE: begin
                if (!w_locked_s) begin
                    w_fail = 1'b1;
                end else if (timer_q == c_stable_last) begin
                    state_d = RUN;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            RUN: begin
                timer_d = '0;
                if (!w_locked_s) begin
                    state_d = RESET_PLL;
                end
            end
            FAULT: begin
                timer_d = '0;
            end
            default: begin
                state_d = RESET_PLL;
                timer_d = '0;
            end
        endcase

        if (w_fail) begin
            timer_d = '0;
            if (retry_q == c_retry_last) begin
                state_d = FAULT;
            end else begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = RESET_PLL;
            end
        end

        if (restart) begin
            state_d = RESET_PLL;
            timer_d = '0;
            retry_d = '0;
        end

        // Outputs are registered from the next state so they move with it.
        pll_areset_d = (state_d == RESET_PLL);
        sys_rst_d    = (state_d != RUN);
        fault_d      = (state_d == FAULT);
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q      <= RESET_PLL;
            timer_q      <= '0;
            retry_q      <= '0;
            sync_q       <= '0;
            pll_areset_q <= 1'b1;
            sys_rst_q    <= 1'b1;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            sync_q       <= sync_d;
            pll_areset_q <= pll_areset_d;
            sys_rst_q    <= sys_rst_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_areset = pll_areset_q;
    assign sys_rst    = sys_rst_q;
    assign ready      = ~sys_rst_q;
    assign fault      = fault_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // A restart coinciding with a drop is not a lock loss.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_q == RUN) && !w_locked_s && !restart && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Self-checking bench for pll_reset_sequencer; expected waveforms are
//            derived arithmetically from edge indices of each scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int AR = 4;
    localparam int LT = 20;
    localparam int SC = 8;
    localparam int MR = 2;
    localparam int CW = 2;
    localparam int PERIOD = AR + LT;

    logic          ref_clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          restart = 1'b0;
    logic          pll_areset;
    logic          sys_rst;
    logic          ready;
    logic          fault;
    logic [CW-1:0] lock_loss_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    pll_reset_sequencer #(
        .ARESET_CYCLES (AR),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .CNT_W         (CW)
    ) dut (
        .ref_clk       (ref_clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .restart       (restart),
        .pll_areset    (pll_areset),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .fault         (fault),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 ref_clk = ~ref_clk;

    function automatic int exp_cnt(input int n);
`ifdef PLL_SEQ_LOSS_CNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge ref_clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ar, input logic sr,
                            input logic ft, input int cnt);
        chk({tag, ".pll_areset"}, 32'(pll_areset), 32'(ar));
        chk({tag, ".sys_rst"}, 32'(sys_rst), 32'(sr));
        chk({tag, ".ready"}, 32'(ready), 32'(!sr));
        chk({tag, ".fault"}, 32'(fault), 32'(ft));
        chk({tag, ".lock_loss_cnt"}, 32'(lock_loss_cnt), 32'(cnt));
    endtask

    // Leaves the last rst-high edge as edge 0 of the next sequence.
    task automatic do_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        restart    = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // pll_locked first sampled high at edge e; ready expected at e+2+SC.
    task automatic run_lock(input int e, input int cnt);
        for (int j = 1; j <= e + SC + 4; j++) begin
            if (j == e) pll_locked = 1'b1;
            step();
            chk_outs("lock", j < AR, j < e + 2 + SC, 1'b0, cnt);
        end
    endtask

    // pll_locked never high: MR pulses, each followed by LT cycles of waiting.
    task automatic run_timeout();
        for (int j = 1; j <= MR * PERIOD + 4; j++) begin
            step();
            chk_outs("timeout", (j < MR * PERIOD) && ((j % PERIOD) < AR), 1'b1,
                     j >= MR * PERIOD, 0);
        end
    endtask

    // Lock held for h samples from edge e, then lost during STABLE.
    task automatic run_unstable(input int e, input int h);
        int d;
        d = e + h + 2;
        for (int j = 1; j <= d + PERIOD + 3; j++) begin
            if (j == e) pll_locked = 1'b1;
            if (j == e + h) pll_locked = 1'b0;
            step();
            chk_outs("unstable", (j < AR) || ((j >= d) && (j < d + AR)), 1'b1,
                     j >= d + PERIOD, 0);
        end
    endtask

    initial begin
        int e;
        int run_len;
        int dly;
        int s;

        do_reset();
        chk_outs("reset", 1'b1, 1'b1, 1'b0, 0);

        // Clean lock, including lock on the very cycle the timeout expires.
        run_lock(LT + 2, 0);
        do_reset();
        run_lock(10, 0);
        do_reset();
        run_lock(int'($urandom_range(3, LT + 1)), 0);

        // Unstable lock during qualification consumes the retry.
        do_reset();
        run_unstable(int'($urandom_range(3, 15)), 5);
        do_reset();
        run_unstable(int'($urandom_range(3, 15)), int'($urandom_range(1, SC - 1)));

        // Timeouts to fault, lock activity ignored, then restart.
        do_reset();
        run_timeout();
        for (int i = 0; i < 20; i++) begin
            pll_locked = 1'($urandom_range(0, 1));
            step();
            chk_outs("fault_hold", 1'b0, 1'b1, 1'b1, 0);
        end
        pll_locked = 1'b0;
        repeat (3) begin
            step();
            chk_outs("fault_idle", 1'b0, 1'b1, 1'b1, 0);
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk_outs("restart_fault", 1'b1, 1'b1, 1'b0, 0);
        run_timeout();

        // Lock losses in RUN with counter saturation.
        do_reset();
        run_lock(int'($urandom_range(3, LT + 1)), 0);
        for (int n = 1; n <= 5; n++) begin
            run_len = int'($urandom_range(1, 4));
            repeat (run_len) begin
                step();
                chk_outs("run", 1'b0, 1'b0, 1'b0, exp_cnt(n - 1));
            end
            dly = int'($urandom_range(1, 8));
            s   = (dly + 3 > AR + 4) ? dly + 3 : AR + 4;
            pll_locked = 1'b0;
            for (int k = 1; k <= s + SC + 1; k++) begin
                if (k == 1 + dly) pll_locked = 1'b1;
                step();
                chk_outs("loss", (k >= 3) && (k < 3 + AR), (k >= 3) && (k < s + SC),
                         1'b0, (k >= 3) ? exp_cnt(n) : exp_cnt(n - 1));
            end
        end

        // Restart in RUN is not a lock loss; then full re-lock.
        pll_locked = 1'b0;
        restart    = 1'b1;
        step();
        restart = 1'b0;
        chk_outs("restart_run", 1'b1, 1'b1, 1'b0, exp_cnt(5));
        e = int'($urandom_range(3, LT + 1));
        run_lock(e, exp_cnt(5));

        // rst in RUN applies reset values on the next edge.
        rst = 1'b1;
        step();
        chk_outs("rst_run", 1'b1, 1'b1, 1'b0, 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
